// File: rtl/max_finder_pkg.sv
// Shared network package: Q6.10 number format and the max-finder FSM states.
package max_finder_pkg;

    localparam int Q_INT_BITS  = 6;
    localparam int Q_FRAC_BITS = 10;
    localparam int Q_WIDTH     = Q_INT_BITS + Q_FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/max_finder.sv
// Sequential argmax over a captured vector of signed Q6.10 neuron outputs.
// One element is compared per cycle against the running best.
module max_finder
    import max_finder_pkg::*;
#(
    parameter int numInputs  = 16,
    parameter int dataWidth  = Q_WIDTH,
    parameter int indexWidth = (numInputs > 1) ? $clog2(numInputs) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [dataWidth*numInputs-1:0]  dataIn,
    input  logic                            dataValid,
    output logic                            busy,
    output logic [indexWidth-1:0]           maxIndex,
    output logic [dataWidth-1:0]            maxValue,
    output logic                            outValid,
    output logic                            overrun
);

    localparam int cntWidth = $clog2(numInputs + 1);
    localparam int vecWidth = dataWidth * numInputs;

    state_t state, next_state;

    logic [vecWidth-1:0]   vec;
    logic [vecWidth-1:0]   shifted;
    logic [dataWidth-1:0]  cur;
    logic [dataWidth-1:0]  best;
    logic [indexWidth-1:0] best_idx;
    logic [cntWidth-1:0]   count;
    logic                  last;
    logic                  greater;
    logic [dataWidth-1:0]  win_val;
    logic [indexWidth-1:0] win_idx;

    // The vector shifts down one element per scan cycle, so the element
    // under comparison always sits in the second-lowest slot.
    assign shifted = vec >> dataWidth;
    assign cur     = shifted[dataWidth-1:0];
    assign last    = (count == cntWidth'(numInputs - 1));
    assign greater = $signed(cur) > $signed(best);
    assign win_val = greater ? cur : best;
    assign win_idx = greater ? count[indexWidth-1:0] : best_idx;

    assign busy     = (state != IDLE);
    assign outValid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dataValid) begin
                    next_state = (numInputs == 1) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vec      <= '0;
            best     <= '0;
            best_idx <= '0;
            count    <= '0;
            maxIndex <= '0;
            maxValue <= '0;
            overrun  <= 1'b0;
        end else begin
            if (dataValid && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (dataValid) begin
                        vec      <= dataIn;
                        best     <= dataIn[dataWidth-1:0];
                        best_idx <= '0;
                        count    <= cntWidth'(1);
                        if (numInputs == 1) begin
                            maxIndex <= '0;
                            maxValue <= dataIn[dataWidth-1:0];
                        end
                    end
                end
                SCAN: begin
                    vec      <= shifted;
                    best     <= win_val;
                    best_idx <= win_idx;
                    count    <= count + cntWidth'(1);
                    if (last) begin
                        maxIndex <= win_idx;
                        maxValue <= win_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
